// File: rtl/fp_pkg.sv
// Shared single-precision constants and the float-to-int FSM state encoding.
package fp_pkg;

  // IEEE-754 single field positions
  localparam int SIGN_BIT    = 31;
  localparam int EXP_HI      = 30;
  localparam int EXP_LO      = 23;
  localparam int MAN_HI      = 22;
  localparam int EXP_BIAS    = 127;
  localparam int EXP_SPECIAL = 255;

  // Result for NaN, infinities and magnitudes that do not fit in int32
  localparam logic [31:0] INT_INDEFINITE_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    GET_A         = 3'd0,
    UNPACK        = 3'd1,
    SPECIAL_CASES = 3'd2,
    CONVERT       = 3'd3,
    ROUND         = 3'd4,
    APPLY_SIGN    = 3'd5,
    PUT_Z         = 3'd6
  } state_t;

endpackage

// File: rtl/float_to_int_converter.sv
// IEEE single -> int32 converter, stb/ack handshake on both sides.
// Magnitude is aligned by a one-bit-per-cycle shifter (no barrel shifter).
// Build option: define FLOAT_TO_INT_ROUND_NEAREST_EN for round-to-nearest-even;
// default build truncates toward zero.
module float_to_int_converter
  import fp_pkg::*;
#(
  parameter logic [31:0] INT_INDEFINITE = INT_INDEFINITE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t             state, state_n;
  logic [31:0]        a, a_n;
  logic [31:0]        m, m_n;
  logic [31:0]        z, z_n;
  logic signed [9:0]  e, e_n;
  logic               s, s_n;
  logic               ack_n, stb_n;
  logic [31:0]        out_z_n;
  logic [7:0]         exp_field;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
  logic               guard, guard_n;
  logic               sticky, sticky_n;
`endif

  assign exp_field = a[EXP_HI:EXP_LO];

  // State and datapath registers; reset discards any operand in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      a            <= '0;
      m            <= '0;
      z            <= '0;
      e            <= '0;
      s            <= 1'b0;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
      guard        <= 1'b0;
      sticky       <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      a            <= a_n;
      m            <= m_n;
      z            <= z_n;
      e            <= e_n;
      s            <= s_n;
      input_a_ack  <= ack_n;
      output_z_stb <= stb_n;
      output_z     <= out_z_n;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
      guard        <= guard_n;
      sticky       <= sticky_n;
`endif
    end
  end

  // Next-state and datapath updates; everything holds unless a state changes it
  always_comb begin
    state_n = state;
    a_n     = a;
    m_n     = m;
    z_n     = z;
    e_n     = e;
    s_n     = s;
    ack_n   = input_a_ack;
    stb_n   = output_z_stb;
    out_z_n = output_z;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    guard_n  = guard;
    sticky_n = sticky;
`endif
    case (state)
      GET_A: begin
        ack_n = 1'b1;
        if (input_a_ack && input_a_stb) begin
          a_n     = input_a;
          ack_n   = 1'b0;
          state_n = UNPACK;
        end
      end
      UNPACK: begin
        m_n = {1'b1, a[MAN_HI:0], 8'b0};
        e_n = {2'b00, exp_field} - 10'(EXP_BIAS);
        s_n = a[SIGN_BIT];
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        guard_n  = 1'b0;
        sticky_n = 1'b0;
`endif
        state_n = SPECIAL_CASES;
      end
      SPECIAL_CASES: begin
        state_n = PUT_Z;
        if (exp_field == 8'(EXP_SPECIAL)) begin
          z_n = INT_INDEFINITE;
        end else if (exp_field == 8'd0) begin
          z_n = '0;
        end else if (e > 10'sd30) begin
          // also catches exactly -2^31, whose int32 pattern equals INT_INDEFINITE
          z_n = INT_INDEFINITE;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        end else if (e < -10'sd1) begin
          z_n = '0;
`else
        end else if (e < 10'sd0) begin
          z_n = '0;
`endif
        end else begin
          state_n = CONVERT;
        end
      end
      CONVERT: begin
        // Leave on the edge that performs the final shift so e ends at 31
        if (e < 10'sd31) begin
          m_n = m >> 1;
          e_n = e + 10'sd1;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
          guard_n  = m[0];
          sticky_n = sticky | guard;
          if (e == 10'sd30) state_n = ROUND;
`else
          if (e == 10'sd30) state_n = APPLY_SIGN;
`endif
        end else begin
          state_n = APPLY_SIGN;
        end
      end
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
      ROUND: begin
        if (guard && (sticky || m[0])) m_n = m + 32'd1;
        state_n = APPLY_SIGN;
      end
`endif
      APPLY_SIGN: begin
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        // Rounding can carry the magnitude up to 2^31, which no longer fits
        if (m[31]) z_n = INT_INDEFINITE;
        else       z_n = s ? -m : m;
`else
        z_n = s ? -m : m;
`endif
        state_n = PUT_Z;
      end
      PUT_Z: begin
        stb_n   = 1'b1;
        out_z_n = z;
        if (output_z_stb && output_z_ack) begin
          stb_n   = 1'b0;
          state_n = GET_A;
        end
      end
      default: state_n = GET_A;
    endcase
  end

endmodule

// File: tb/tb_float_to_int_converter.sv
// Directed-vector bench for float_to_int_converter (both rounding builds).
module tb_float_to_int_converter;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks = 0;
  int errors = 0;

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  float_to_int_converter dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for input_a_ack, then present one operand for exactly one edge
  task automatic send(input string tag, input logic [31:0] val);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (input_a_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_seen"}, {31'b0, ok}, 32'd1);
    if (ok) begin
      input_a     = val;
      input_a_stb = 1'b1;
      @(posedge clk);
      #1 input_a_stb = 1'b0;
    end
  endtask

  // Count edges from the accept edge until output_z_stb is high
  task automatic wait_stb(input string tag, output int lat);
    lat = 0;
    while (output_z_stb !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_stb_seen"}, {31'b0, output_z_stb}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] val,
                        input logic [31:0] exp_z, input int exp_lat);
    int lat;
    send(tag, val);
    wait_stb(tag, lat);
    chk({tag, "_z"}, output_z, exp_z);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
    chk({tag, "_stb_drop"}, {31'b0, output_z_stb}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] z0;
    int stray;

    rst          = 1'b0;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, input_a_ack}, 32'd0);
    chk("rst_stb", {31'b0, output_z_stb}, 32'd0);
    chk("rst_z",   output_z, 32'd0);
    @(negedge clk) rst = 1'b1;

    // Convert path latency is 4 + (31 - e), plus one round cycle when enabled
    run_op("one",      32'h3F80_0000, 32'h0000_0001, 35 + RND);
    run_op("m123",     32'hC2F6_0000, 32'hFFFF_FF85, 4 + 25 + RND);
    run_op("one_half", 32'h3FC0_0000, (RND != 0) ? 32'd2 : 32'd1, 35 + RND);
    run_op("two_half", 32'h4020_0000, 32'd2, 34 + RND);
    run_op("p2_31",    32'h4F00_0000, 32'h8000_0000, 3);
    run_op("m2_31",    32'hCF00_0000, 32'h8000_0000, 3);
    run_op("max_fit",  32'h4EFF_FFFF, 32'h7FFF_FF80, 5 + RND);
    run_op("nan",      32'h7FC0_0000, 32'h8000_0000, 3);
    run_op("minf",     32'hFF80_0000, 32'h8000_0000, 3);
    run_op("denorm",   32'h0000_0001, 32'h0000_0000, 3);
    run_op("mzero",    32'h8000_0000, 32'h0000_0000, 3);
    run_op("quarter",  32'h3E80_0000, 32'h0000_0000, 3);
    run_op("m7",       32'hC0E0_0000, 32'hFFFF_FFF9, 4 + 29 + RND);

    // Backpressure: result must hold while the consumer stalls
    send("bp", 32'h3F80_0000);
    wait_stb("bp", lat);
    z0 = output_z;
    chk("bp_z", z0, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_stb", {31'b0, output_z_stb}, 32'd1);
      chk("bp_hold_z",   output_z, z0);
      chk("bp_hold_ack", {31'b0, input_a_ack}, 32'd0);
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
    chk("bp_stb_drop", {31'b0, output_z_stb}, 32'd0);
    chk("bp_ack_low",  {31'b0, input_a_ack}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_ack_back", {31'b0, input_a_ack}, 32'd1);

    // Reset in the middle of the shift loop discards the operand
    send("rmid", 32'h3F80_0000);
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rmid_stb", {31'b0, output_z_stb}, 32'd0);
    chk("rmid_z",   output_z, 32'd0);
    chk("rmid_ack", {31'b0, input_a_ack}, 32'd0);
    @(negedge clk) rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (output_z_stb !== 1'b0) stray++;
    end
    chk("rmid_no_result", stray, 0);
    run_op("three", 32'h4040_0000, 32'd3, 34 + RND);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
